// File: rtl/raster_sched_pkg.sv
// Shared types and helpers for the rasterizer sample scheduler.
// Holds the coordinate format, FSM state encoding, MSAA one-hot type and the
// sample-step helper used by sample_scheduler and sample_walker.
package raster_sched_pkg;

  localparam int unsigned SIGFIG = 24;  // bits per coordinate/color
  localparam int unsigned RADIX  = 10;  // fraction bits; one pixel = 1<<RADIX
  localparam int unsigned VERTS  = 3;
  localparam int unsigned AXIS   = 3;
  localparam int unsigned COLORS = 3;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic {IDLE = 1'b0, TEST = 1'b1} sched_state_t;

  typedef logic [3:0] msaa_onehot_t;

  typedef logic signed [SIGFIG-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  // Sample spacing: 1x -> 1 pixel, each MSAA level halves the step.
  function automatic coord_t step_from_msaa(input msaa_onehot_t msaa, input int unsigned radix);
    coord_t one;
    one = coord_t'(1);
    case (msaa)
      4'b0100: return one << (radix - 1);
      4'b0010: return one << (radix - 2);
      4'b0001: return one << (radix - 3);
      default: return one << radix;
    endcase
  endfunction

endpackage

// File: rtl/sample_walker.sv
// Box walker: latches the bounding box and step, walks sample positions in
// row-major order and flags the last position of the box.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   load_i      latch ll/ur/step and start at LL
//   adv_i       advance to the next sample
//   ll_i, ur_i  box corners, step_i sample spacing
//   pos_o       current sample position (registered)
//   last_c_o    current position is the UR corner (combinational)
module sample_walker
  import raster_sched_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   adv_i,
  input  point_t ll_i,
  input  point_t ur_i,
  input  coord_t step_i,
  output point_t pos_o,
  output logic   last_c_o
);

  point_t ll_q, ur_q, pos_q, pos_d;
  coord_t step_q;

  // Next position: load wins, otherwise step along x and wrap to the next row.
  always_comb begin
    pos_d = pos_q;
    if (load_i) begin
      pos_d = ll_i;
    end else if (adv_i) begin
      if (pos_q.x == ur_q.x) begin
        pos_d.x = ll_q.x;
        pos_d.y = pos_q.y + step_q;
      end else begin
        pos_d.x = pos_q.x + step_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ll_q   <= '0;
      ur_q   <= '0;
      pos_q  <= '0;
      step_q <= '0;
    end else begin
      pos_q <= pos_d;
      if (load_i) begin
        ll_q   <= ll_i;
        ur_q   <= ur_i;
        step_q <= step_i;
      end
    end
  end

  // Box corners must sit on the sample grid, otherwise the walk never hits UR.
  always @(posedge clk) begin
    if (!rst && load_i) begin
      assert (((ll_i.x | ll_i.y | ur_i.x | ur_i.y) & (step_i - coord_t'(1))) == '0)
        else $error("sample_walker: box not aligned to sample step");
    end
  end

  assign pos_o    = pos_q;
  assign last_c_o = (pos_q.x == ur_q.x) && (pos_q.y == ur_q.y);

endmodule

// File: rtl/sample_scheduler.sv
// Walks the bounding box of one triangle and emits one sample position per
// cycle to the sample-test stage; holds upstream with halt during a walk and
// freezes on downstream stall.
// Optional feature macro: SCHED_STATS_EN adds triCount_U / sampCount_U.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   tri_R13S, color_R13U, box_R13S, validTri_R13H   triangle from bbox stage
//   subSample_RnnnnU   one-hot MSAA select (1000=1x .. 0001=64x)
//   stall_R14H         downstream stall
//   halt_RnnnnH        upstream hold
//   tri_R14S, color_R14U, sample_R14S, validSamp_R14H   to sampletest
module sample_scheduler
  import raster_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  coord_t       tri_R13S   [VERTS][AXIS],
  input  coord_t       color_R13U [COLORS],
  input  coord_t       box_R13S   [2][2],
  input  logic         validTri_R13H,
  input  msaa_onehot_t subSample_RnnnnU,
  input  logic         stall_R14H,
  output logic         halt_RnnnnH,
  output coord_t       tri_R14S   [VERTS][AXIS],
  output coord_t       color_R14U [COLORS],
  output coord_t       sample_R14S [2],
  output logic         validSamp_R14H
`ifdef SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0] triCount_U,
  output logic [CNT_W-1:0] sampCount_U
`endif
);

  sched_state_t state_q, state_d;
  coord_t       tri_q   [VERTS][AXIS];
  coord_t       color_q [COLORS];

  logic   box_ok_c, accept_c, adv_c, halt_c, last_c;
  point_t ll_c, ur_c, pos;
  coord_t step_c;

  assign ll_c   = '{x: box_R13S[0][0], y: box_R13S[0][1]};
  assign ur_c   = '{x: box_R13S[1][0], y: box_R13S[1][1]};
  assign step_c = step_from_msaa(subSample_RnnnnU, RADIX);

  // Next state, accept, advance and halt decode.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    adv_c    = 1'b0;
    halt_c   = 1'b0;
    box_ok_c = validTri_R13H && (ll_c.x <= ur_c.x) && (ll_c.y <= ur_c.y);
    case (state_q)
      IDLE: begin
        if (!stall_R14H && box_ok_c) begin
          accept_c = 1'b1;
          state_d  = TEST;
        end
      end
      TEST: begin
        halt_c = !(last_c && !stall_R14H);
        if (!stall_R14H) begin
          if (!last_c) begin
            adv_c = 1'b1;
          end else if (box_ok_c) begin
            // Back-to-back: next triangle starts right after the last sample.
            accept_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tri_q   <= '{default: '0};
      color_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        tri_q   <= tri_R13S;
        color_q <= color_R13U;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && accept_c) begin
      assert ($onehot(subSample_RnnnnU))
        else $error("sample_scheduler: subSample not one-hot");
    end
  end

  sample_walker u_walker (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept_c),
    .adv_i    (adv_c),
    .ll_i     (ll_c),
    .ur_i     (ur_c),
    .step_i   (step_c),
    .pos_o    (pos),
    .last_c_o (last_c)
  );

  assign halt_RnnnnH    = halt_c;
  assign validSamp_R14H = (state_q == TEST);
  assign tri_R14S       = tri_q;
  assign color_R14U     = color_q;
  assign sample_R14S[0] = pos.x;
  assign sample_R14S[1] = pos.y;

`ifdef SCHED_STATS_EN
  logic [CNT_W-1:0] tri_cnt_q, samp_cnt_q;

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      tri_cnt_q  <= '0;
      samp_cnt_q <= '0;
    end else begin
      if (accept_c && (tri_cnt_q != '1)) tri_cnt_q <= tri_cnt_q + CNT_W'(1);
      if (validSamp_R14H && !stall_R14H && (samp_cnt_q != '1)) samp_cnt_q <= samp_cnt_q + CNT_W'(1);
    end
  end

  assign triCount_U  = tri_cnt_q;
  assign sampCount_U = samp_cnt_q;
`endif

endmodule
